// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Sequencing controller for the 16-bit five-stage CPU (IF, ID, EX, MEM, WB).
// It keeps a three-slot record of the destination registers held by the
// instructions in EX, MEM and WB. From that record it interlocks ID on
// read-after-write hazards and squashes the front end on taken branches.
// It also drains the pipeline after a HALT before it reports halted.
//
// Parameters
//   WB_BYPASS   1: the register file writes in the first half-cycle, so a
//               match in the WB slot is not a hazard.
//               0: the WB slot also interlocks.
//   CNT_W       width of the saturating stall-cycle counter.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   id_valid         ID holds a real instruction
//   id_rs1, id_rs2   source register fields (instr[11:8], instr[7:4])
//   id_use_rs1/2     the instruction reads rs1 / rs2
//   id_wr1           the instruction writes the rs1-field register
//   id_wr2           the instruction also writes the rs2-field register
//   id_halt          the ID instruction is HALT
//   ex_branch_taken  a branch or jump in EX resolved taken this cycle
//   pc_en            PC update enable
//   ifid_en          IF/ID load enable
//   ifid_flush       clear IF/ID to NOP on the next edge
//   idex_bubble      load NOP into ID/EX on the next edge
//   halted           the pipeline has fully drained after a HALT
//   busy_mask        bit n is set when register n has a pending write
//   stall_cycles     saturating count of RAW-interlock cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wr1,
    input  logic             id_wr2,
    input  logic             id_halt,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [15:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       v;
        logic       wr1;
        logic [3:0] rd1;
        logic       wr2;
        logic [3:0] rd2;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The WB slot takes part in hazards and busy_mask only without the
    // half-cycle register-file bypass.
    localparam logic WB_CHECK = (WB_BYPASS == 0);

    slot_t            ex_reg, mem_reg, wb_reg;
    slot_t            ex_next;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_reg, stall_next;

    logic hazard;
    logic pc_en_next, ifid_en_next, ifid_flush_next, idex_bubble_next;

    // The slot holds a valid record that writes register r.
    function automatic logic slot_writes(input slot_t s, input logic [3:0] r);
        return s.v && ((s.wr1 && (s.rd1 == r)) || (s.wr2 && (s.rd2 == r)));
    endfunction

    function automatic logic reg_pending(input logic [3:0] r,
                                         input slot_t e, input slot_t m,
                                         input slot_t w);
        return slot_writes(e, r) || slot_writes(m, r) ||
               (WB_CHECK && slot_writes(w, r));
    endfunction

    assign hazard = (id_use_rs1 && reg_pending(id_rs1, ex_reg, mem_reg, wb_reg)) ||
                    (id_use_rs2 && reg_pending(id_rs2, ex_reg, mem_reg, wb_reg));

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_busy
            assign busy_mask[gi] = reg_pending(4'(gi), ex_reg, mem_reg, wb_reg);
        end
    endgenerate

    always_comb begin
        pc_en_next       = 1'b0;
        ifid_en_next     = 1'b0;
        ifid_flush_next  = 1'b0;
        idex_bubble_next = 1'b0;
        ex_next          = '0;
        state_next       = state_reg;
        stall_next       = stall_reg;

        case (state_reg)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // Squash the wrong-path instructions in IF and ID.
                    // This case takes priority over any interlock.
                    pc_en_next       = 1'b1;
                    ifid_en_next     = 1'b1;
                    ifid_flush_next  = 1'b1;
                    idex_bubble_next = 1'b1;
                end else if (id_valid && hazard) begin
                    idex_bubble_next = 1'b1;
                    if (stall_reg != {CNT_W{1'b1}})
                        stall_next = stall_reg + CNT_W'(1);
                end else if (id_valid && id_halt) begin
                    // HALT enters EX as a bubble. It carries no write, so the
                    // drain waits only for the older instructions.
                    idex_bubble_next = 1'b1;
                    state_next       = ST_DRAIN;
                end else begin
                    pc_en_next   = 1'b1;
                    ifid_en_next = 1'b1;
                    if (id_valid) begin
                        ex_next.v   = 1'b1;
                        ex_next.wr1 = id_wr1;
                        ex_next.rd1 = id_rs1;
                        ex_next.wr2 = id_wr2;
                        ex_next.rd2 = id_rs2;
                    end
                end
            end
            ST_DRAIN: begin
                idex_bubble_next = 1'b1;
                if (!ex_reg.v && !mem_reg.v && !wb_reg.v)
                    state_next = ST_HALTED;
            end
            ST_HALTED: begin
                idex_bubble_next = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Every control output is held low while reset is asserted. Without this
    // gating, the RUN state would drive pc_en during reset.
    assign pc_en        = rst && pc_en_next;
    assign ifid_en      = rst && ifid_en_next;
    assign ifid_flush   = rst && ifid_flush_next;
    assign idex_bubble  = rst && idex_bubble_next;
    assign halted       = rst && (state_reg == ST_HALTED);
    assign stall_cycles = stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_reg    <= '0;
            mem_reg   <= '0;
            wb_reg    <= '0;
            state_reg <= ST_RUN;
            stall_reg <= '0;
        end else begin
            ex_reg    <= ex_next;
            mem_reg   <= ex_reg;
            wb_reg    <= mem_reg;
            state_reg <= state_next;
            stall_reg <= stall_next;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two controllers receive the same inputs:
//   dut0  WB_BYPASS=1, CNT_W=16
//   dut1  WB_BYPASS=0, CNT_W=3  (the narrow counter reaches saturation)
//
// The reference model tracks time, not pipeline slots. It stores the cycle in
// which each register was last written at issue, and the cycle of the most
// recent issue. A write issued in cycle c is pending during cycles c+1..c+W.
// W is 2 with the bypass and 3 without it.
//
// The driver pushes the expected outputs into a queue for each cycle. The
// monitor pops each entry at the falling edge and compares it.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wr1, id_wr2, id_halt;
    logic [3:0] id_rs1, id_rs2;
    logic       ex_branch_taken;

    logic [1:0]  pc_en, ifid_en, ifid_flush, idex_bubble, halted;
    logic [15:0] busy0, busy1;
    logic [15:0] stall0;
    logic [2:0]  stall1;

    pipe_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr1(id_wr1), .id_wr2(id_wr2),
        .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
        .idex_bubble(idex_bubble[0]), .halted(halted[0]), .busy_mask(busy0),
        .stall_cycles(stall0)
    );

    pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr1(id_wr1), .id_wr2(id_wr2),
        .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
        .idex_bubble(idex_bubble[1]), .halted(halted[1]), .busy_mask(busy1),
        .stall_cycles(stall1)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  ctrl;   // {pc_en, ifid_en, ifid_flush, idex_bubble}
        logic        halted;
        logic [15:0] busy;
        int          stall;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    // Reference model state, one copy per DUT.
    // m_state: 0 = running, 1 = draining, 2 = halted.
    int m_last_wr [2][16];
    int m_last_issue [2];
    int m_state [2];
    int m_cnt [2];
    int now = 0;

    function automatic int win(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    function automatic logic pending(input int k, input logic [3:0] r);
        int d;
        d = now - m_last_wr[k][r];
        return (d >= 1) && (d <= win(k));
    endfunction

    task automatic model_reset(input int k);
        for (int j = 0; j < 16; j++) m_last_wr[k][j] = -1000;
        m_last_issue[k] = -1000;
        m_state[k]      = 0;
        m_cnt[k]        = 0;
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic u1, input logic u2,
                         input logic w1, input logic w2, input logic h,
                         input logic br);
        exp_t e;
        logic haz;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_use_rs1 = u1;
        id_use_rs2 = u2; id_wr1 = w1; id_wr2 = w2; id_halt = h;
        ex_branch_taken = br;
        for (int k = 0; k < 2; k++) begin
            e.cyc = now; e.ctrl = 4'b0000; e.halted = 1'b0; e.busy = '0; e.stall = 0;
            if (!r) begin
                model_reset(k);
            end else begin
                for (int j = 0; j < 16; j++) e.busy[j] = pending(k, 4'(j));
                e.stall  = m_cnt[k];
                e.halted = (m_state[k] == 2);
                haz = (u1 && pending(k, a)) || (u2 && pending(k, b));
                if (m_state[k] == 0) begin
                    if (br) begin
                        e.ctrl = 4'b1111;
                    end else if (v && haz) begin
                        e.ctrl = 4'b0001;
                        if (m_cnt[k] < cmax(k)) m_cnt[k]++;
                    end else if (v && h) begin
                        e.ctrl = 4'b0001;
                        m_state[k] = 1;
                    end else begin
                        e.ctrl = 4'b1100;
                        if (v) begin
                            m_last_issue[k] = now;
                            if (w1) m_last_wr[k][a] = now;
                            if (w2) m_last_wr[k][b] = now;
                        end
                    end
                end else begin
                    e.ctrl = 4'b0001;
                    // Draining: the last real instruction has left WB once
                    // more than three cycles have passed since it issued.
                    if (m_state[k] == 1 && (now - m_last_issue[k]) > 3)
                        m_state[k] = 2;
                end
            end
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        now++;
    endtask

    task automatic check(input int k, input exp_t e, input logic [3:0] c,
                         input logic hl, input logic [15:0] bm, input int sc);
        total++;
        if (c !== e.ctrl) begin
            bad++;
            $display("FAIL dut%0d cyc %0d ctrl{pc,ifid,flush,bubble}: got %b want %b", k, e.cyc, c, e.ctrl);
        end
        total++;
        if (hl !== e.halted) begin
            bad++;
            $display("FAIL dut%0d cyc %0d halted: got %b want %b", k, e.cyc, hl, e.halted);
        end
        total++;
        if (bm !== e.busy) begin
            bad++;
            $display("FAIL dut%0d cyc %0d busy_mask: got %h want %h", k, e.cyc, bm, e.busy);
        end
        total++;
        if (sc != e.stall) begin
            bad++;
            $display("FAIL dut%0d cyc %0d stall_cycles: got %0d want %0d", k, e.cyc, sc, e.stall);
        end
    endtask

    // Monitor: one line per cycle transaction.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, e, {pc_en[0], ifid_en[0], ifid_flush[0], idex_bubble[0]},
                  halted[0], busy0, int'(stall0));
            $display("cyc %0d rst=%b v=%b rs=%0d,%0d br=%b | dut0 ctrl=%b h=%b busy=%h st=%0d | dut1 ctrl=%b h=%b busy=%h st=%0d",
                     e.cyc, rst, id_valid, id_rs1, id_rs2, ex_branch_taken,
                     {pc_en[0], ifid_en[0], ifid_flush[0], idex_bubble[0]}, halted[0], busy0, stall0,
                     {pc_en[1], ifid_en[1], ifid_flush[1], idex_bubble[1]}, halted[1], busy1, stall1);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, e, {pc_en[1], ifid_en[1], ifid_flush[1], idex_bubble[1]},
                  halted[1], busy1, int'(stall1));
        end
    end

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_wr1 = 0; id_wr2 = 0; id_halt = 0; ex_branch_taken = 0;
        model_reset(0);
        model_reset(1);

        // Reset, then three independent instructions.
        drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'd1, 4'd2, 1, 1, 1, 0, 0, 0);
        drive(1, 1, 4'd8, 4'd1, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 4'd9, 4'd2, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 4'd10, 4'd3, 0, 1, 1, 0, 0, 0);
        nop(4);

        // ADD writes R3, then a reader of R3 is held in ID.
        drive(1, 1, 4'd3, 4'd4, 1, 1, 1, 0, 0, 0);
        repeat (4) drive(1, 1, 4'd3, 4'd6, 1, 1, 0, 0, 0, 0);
        nop(4);

        // MUL writes R4 and R5, then a reader of R5.
        drive(1, 1, 4'd4, 4'd5, 1, 1, 1, 1, 0, 0);
        repeat (4) drive(1, 1, 4'd7, 4'd5, 0, 1, 0, 0, 0, 0);
        nop(4);

        // A taken branch during a hazard stall.
        drive(1, 1, 4'd6, 4'd0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 4'd6, 4'd0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 4'd6, 4'd0, 1, 0, 0, 0, 0, 1);
        nop(4);

        // A writer of R2, then HALT. The run drains and holds halted, then resets.
        drive(1, 1, 4'd2, 4'd0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
        repeat (7) drive(1, 1, 4'd1, 4'd1, 1, 1, 1, 0, 0, 1);
        drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        nop(2);

        // Reset asserted mid-drain.
        drive(1, 1, 4'd2, 4'd0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
        nop(1);
        drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        nop(3);

        // Saturate the narrow counter: a long stall behind a no-bypass writer.
        for (int n = 0; n < 4; n++) begin
            drive(1, 1, 4'd11, 4'd0, 0, 0, 1, 0, 0, 0);
            repeat (4) drive(1, 1, 4'd11, 4'd0, 1, 0, 0, 0, 0, 0);
        end
        nop(4);

        // Randomised traffic. Small register numbers make hazards frequent.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        // Let the monitor consume the last entries, within a bounded wait.
        for (int t = 0; t < 10 && (q0.size() != 0 || q1.size() != 0); t++)
            @(negedge clk);
        @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: got %0d/%0d entries left want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
